mem_port_arbiter: RTL and testbench

Arbitrates the single unified memory port between the instruction-fetch stage and the MEM-stage data access of the 5-stage pipeline CPU. Accepts level-held requests from both stages and issues one transaction at a time to a variable-latency memory. Returns acknowledge and read data to the winning stage, and drives the pipeline freeze signal. Data accesses take priority over fetches because the MEM-stage instruction is older; fetches in flight can be killed on a branch redirect.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and default widths for the memory port arbiter
package cpu_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port shared by fetch and data access, data first
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_kill_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              err_o
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       kill_pending;
    logic       kill_nxt;
    logic       latch_d;
    logic       latch_i;

    // Grant decision and kill tracking; data wins because its instruction is older
    always_comb begin
        state_nxt = state;
        kill_nxt  = kill_pending;
        latch_d   = 1'b0;
        latch_i   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req_i) begin
                    latch_d   = 1'b1;
                    state_nxt = D_BUSY;
                end else if (if_req_i && !if_kill_i) begin
                    latch_i   = 1'b1;
                    state_nxt = I_BUSY;
                end
            end
            D_BUSY: begin
                if (mem_ack_i) begin
                    state_nxt = IDLE;
                end
            end
            I_BUSY: begin
                if (mem_ack_i) begin
                    state_nxt = IDLE;
                    kill_nxt  = 1'b0;
                end else if (if_kill_i) begin
                    kill_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                kill_nxt  = 1'b0;
            end
        endcase
    end

    // State register; a killed fetch still runs to completion on the memory side
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state        <= IDLE;
            kill_pending <= 1'b0;
        end else begin
            state        <= state_nxt;
            kill_pending <= kill_nxt;
        end
    end

    // Memory command registers, captured at grant and held for the whole transaction
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else if (latch_d) begin
            mem_we_o    <= d_we_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
        end else if (latch_i) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= if_addr_i;
        end
    end

    assign mem_req_o  = (state != IDLE);

    // Acks are gated by reset so the pipeline sees nothing while held in reset
    assign d_ack_o    = start_i && (state == D_BUSY) && mem_ack_i;
    assign if_ack_o   = start_i && (state == I_BUSY) && mem_ack_i && !kill_pending && !if_kill_i;
    assign d_rdata_o  = mem_rdata_i;
    assign if_rdata_o = mem_rdata_i;

    assign stall_o = start_i && ((d_req_i && !d_ack_o) || (if_req_i && !if_ack_o && !if_kill_i));

    // Saturating stall counter and sticky error for an ack with nothing outstanding
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_o <= '0;
            err_o       <= 1'b0;
        end else begin
            if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if ((state == IDLE) && mem_ack_i) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed checks of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          start_i = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic          if_kill_i = 1'b0;
    logic          if_ack_o;
    logic [DW-1:0] if_rdata_o;
    logic          d_req_i = 1'b0;
    logic          d_we_i = 1'b0;
    logic [AW-1:0] d_addr_i = '0;
    logic [DW-1:0] d_wdata_i = '0;
    logic          d_ack_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          stall_o;
    logic [CW-1:0] stall_cnt_o;
    logic          err_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i(clk), .start_i(start_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
        .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
    );

    int tests = 0;
    int fails = 0;

    // transaction-level model: one outstanding access, who owns it, what was latched
    bit          m_busy = 0;
    bit          m_own_i = 0;
    bit          m_killed = 0;
    bit          m_err = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    int          m_cnt = 0;

    bit e_d_ack = 0;
    bit e_if_ack = 0;
    bit e_stall = 0;

    int force_lat = 0;
    int mem_wait = 0;
    bit spurious = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // model advances at each clock edge, and collapses at once on reset
    initial forever begin
        @(posedge clk or negedge start_i);
        if (!start_i) begin
            m_busy = 0; m_own_i = 0; m_killed = 0; m_err = 0;
            m_we = 0; m_addr = '0; m_wdata = '0; m_cnt = 0;
        end else begin
            if (e_stall && m_cnt < CMAX) m_cnt++;
            if (!m_busy) begin
                if (mem_ack_i) m_err = 1;
                if (d_req_i) begin
                    m_busy = 1; m_own_i = 0; m_killed = 0;
                    m_addr = d_addr_i; m_we = d_we_i; m_wdata = d_wdata_i;
                end else if (if_req_i && !if_kill_i) begin
                    m_busy = 1; m_own_i = 1; m_killed = 0;
                    m_addr = if_addr_i; m_we = 0;
                end
            end else if (mem_ack_i) begin
                m_busy = 0; m_killed = 0;
            end else if (m_own_i && if_kill_i) begin
                m_killed = 1;
            end
        end
    end

    // compare process: every falling edge, all outputs against the model
    initial forever begin
        @(negedge clk);
        e_d_ack  = start_i && m_busy && !m_own_i && mem_ack_i;
        e_if_ack = start_i && m_busy && m_own_i && mem_ack_i && !m_killed && !if_kill_i;
        e_stall  = start_i && ((d_req_i && !e_d_ack) || (if_req_i && !e_if_ack && !if_kill_i));
        chk("mem_req", 64'(mem_req_o), 64'(m_busy));
        chk("d_ack", 64'(d_ack_o), 64'(e_d_ack));
        chk("if_ack", 64'(if_ack_o), 64'(e_if_ack));
        chk("stall", 64'(stall_o), 64'(e_stall));
        chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
        chk("err", 64'(err_o), 64'(m_err));
        if (e_d_ack) chk("d_rdata", 64'(d_rdata_o), 64'(mem_rdata_i));
        if (e_if_ack) chk("if_rdata", 64'(if_rdata_o), 64'(mem_rdata_i));
        if (m_busy) begin
            chk("mem_addr", 64'(mem_addr_o), 64'(m_addr));
            chk("mem_we", 64'(mem_we_o), 64'(m_we));
            if (!m_own_i) chk("mem_wdata", 64'(mem_wdata_o), 64'(m_wdata));
        end
    end

    // memory: acks the model's outstanding access after a chosen latency
    initial forever begin
        @(posedge clk or negedge start_i);
        if (!start_i) begin
            mem_ack_i = 0;
            mem_wait = 0;
        end else begin
            #1;
            mem_ack_i = 0;
            if (m_busy) begin
                if (mem_wait == 0) mem_wait = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
                mem_ack_i = (mem_wait == 1);
                mem_wait--;
                mem_rdata_i = 32'($urandom);
            end else if (spurious) begin
                mem_ack_i = 1;
                spurious = 0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        start_i = 0;
        d_req_i = 0; if_req_i = 0; if_kill_i = 0;
        @(posedge clk);
        #2;
        start_i = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit got;
        bit kill_prev;

        @(posedge clk);
        #3;
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_mem_we", 64'(mem_we_o), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);

        // fetch only, latency 3
        do_reset(); force_lat = 3;
        cyc(1); if_req_i = 1; if_addr_i = 32'h10;
        #2 chk("t1_c0_mem_req", 64'(mem_req_o), 64'd0);
        cyc(1); #2;
        chk("t1_c1_mem_req", 64'(mem_req_o), 64'd1);
        chk("t1_c1_mem_addr", 64'(mem_addr_o), 64'h10);
        chk("t1_c1_mem_we", 64'(mem_we_o), 64'd0);
        cyc(1);
        cyc(1); #2 chk("t1_c3_if_ack", 64'(if_ack_o), 64'd1);
        cyc(1); if_req_i = 0;
        #2;
        chk("t1_c4_stall_cnt", 64'(stall_cnt_o), 64'd3);
        chk("t1_model_cnt", 64'(m_cnt), 64'd3);
        chk("t1_c4_mem_req", 64'(mem_req_o), 64'd0);

        // simultaneous store and fetch, latency 1
        do_reset(); force_lat = 1;
        cyc(1);
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h40; d_wdata_i = 32'hDEADBEEF;
        if_req_i = 1; if_addr_i = 32'h20;
        cyc(1); #2;
        chk("t2_c1_d_ack", 64'(d_ack_o), 64'd1);
        chk("t2_c1_mem_addr", 64'(mem_addr_o), 64'h40);
        chk("t2_c1_mem_we", 64'(mem_we_o), 64'd1);
        chk("t2_c1_mem_wdata", 64'(mem_wdata_o), 64'hDEADBEEF);
        chk("t2_c1_if_ack", 64'(if_ack_o), 64'd0);
        cyc(1); d_req_i = 0; d_we_i = 0;
        #2 chk("t2_c2_mem_req", 64'(mem_req_o), 64'd0);
        cyc(1); #2;
        chk("t2_c3_if_ack", 64'(if_ack_o), 64'd1);
        chk("t2_c3_mem_addr", 64'(mem_addr_o), 64'h20);
        cyc(1); if_req_i = 0;

        // kill in the middle of a 4-cycle fetch
        do_reset(); force_lat = 4;
        cyc(1); if_req_i = 1; if_addr_i = 32'h80;
        cyc(2); if_kill_i = 1;
        cyc(1); if_kill_i = 0; if_req_i = 0;
        #2 chk("t3_c3_mem_req", 64'(mem_req_o), 64'd1);
        cyc(1); #2;
        chk("t3_c4_mem_ack", 64'(mem_ack_i), 64'd1);
        chk("t3_c4_if_ack", 64'(if_ack_o), 64'd0);
        chk("t3_c4_mem_req", 64'(mem_req_o), 64'd1);
        cyc(1); #2 chk("t3_c5_mem_req", 64'(mem_req_o), 64'd0);

        // kill together with a request in IDLE
        do_reset(); force_lat = 0;
        cyc(1); if_req_i = 1; if_kill_i = 1;
        cyc(1); if_req_i = 0; if_kill_i = 0;
        #2 chk("t4_c1_mem_req", 64'(mem_req_o), 64'd0);

        // asynchronous reset during a load
        do_reset(); force_lat = 5;
        cyc(1); d_req_i = 1; d_we_i = 0; d_addr_i = 32'h44;
        cyc(1); #2 chk("t5_c1_mem_req", 64'(mem_req_o), 64'd1);
        cyc(1); #1 start_i = 0;
        #1;
        chk("t5_rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("t5_rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
        chk("t5_rst_stall", 64'(stall_o), 64'd0);
        d_req_i = 0;
        @(posedge clk); #2 start_i = 1; force_lat = 2;
        cyc(1); d_req_i = 1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            cyc(1); #2;
            if (d_ack_o) got = 1;
        end
        chk("t5_load_done", 64'(got), 64'd1);
        cyc(1); d_req_i = 0;

        // spurious ack and sticky error
        do_reset(); force_lat = 0;
        cyc(1); spurious = 1;
        cyc(3); #2;
        chk("t6_err", 64'(err_o), 64'd1);
        chk("t6_model_err", 64'(m_err), 64'd1);
        cyc(5); #2 chk("t6_err_sticky", 64'(err_o), 64'd1);

        // stall counter saturation
        do_reset(); force_lat = 25;
        cyc(1); d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100;
        cyc(20); #2;
        chk("t7_stall_sat", 64'(stall_cnt_o), 64'd15);
        chk("t7_model_sat", 64'(m_cnt), 64'd15);
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            cyc(1); #2;
            if (d_ack_o) got = 1;
        end
        chk("t7_load_done", 64'(got), 64'd1);
        cyc(1); d_req_i = 0;
        force_lat = 0;

        // randomized traffic
        do_reset();
        kill_prev = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc(1);
            if ($urandom_range(0, 399) == 0) begin
                #1 start_i = 0;
                d_req_i = 0; if_req_i = 0; if_kill_i = 0;
                @(posedge clk); #2 start_i = 1;
                kill_prev = 0;
                continue;
            end
            if (d_req_i) begin
                if (e_d_ack) d_req_i = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                d_req_i = 1;
                d_we_i = 1'($urandom_range(0, 1));
                d_addr_i = 32'($urandom);
                d_wdata_i = 32'($urandom);
            end
            if_kill_i = 0;
            if (if_req_i) begin
                if (e_if_ack) begin
                    if_req_i = 0;
                end else if (kill_prev) begin
                    if_addr_i = 32'($urandom) & ~32'h3;
                end else if ($urandom_range(0, 9) == 0) begin
                    if_kill_i = 1;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req_i = 1;
                if_addr_i = 32'($urandom) & ~32'h3;
            end
            kill_prev = if_kill_i;
            if ($urandom_range(0, 499) == 0) spurious = 1;
        end
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
